ec_point_engine: RTL

EC_POINT_ENGINE -- requirements
Module: ec_point_engine

---
 rtl/ec_pkg.sv | 28 ++
 rtl/ec_modmul.sv | 82 ++++++++
 rtl/ec_point_engine.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ec_pkg.sv
// ---------------------------------------------------------------------------
// ec_pkg
// Shared definitions for the elliptic-curve point engine:
//   - ec_state_t : engine FSM state encoding
//   - EC_DEF_*   : default field/curve parameters (y^2 = x^3 + 2x + b over GF(17))
//   - EC_GEN_*   : generator point (5,1) and its order 19 for that default curve
// ---------------------------------------------------------------------------
package ec_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_NUMDEN = 3'd2,
        S_INV    = 3'd3,
        S_SLOPE  = 3'd4,
        S_XOUT   = 3'd5,
        S_YOUT   = 3'd6,
        S_DONE   = 3'd7
    } ec_state_t;

    localparam int EC_DEF_WIDTH = 8;
    localparam int EC_DEF_P     = 17;
    localparam int EC_DEF_A     = 2;
    localparam int EC_GEN_X     = 5;
    localparam int EC_GEN_Y     = 1;
    localparam int EC_ORDER     = 19;

endpackage

// File: rtl/ec_modmul.sv
// ---------------------------------------------------------------------------
// ec_modmul
// Bit-serial interleaved modular multiplier: o_p = i_a * i_b mod P.
// Scans i_b MSB first; every cycle acc = 2*acc (+ a) with both steps reduced
// by a single conditional subtraction of P. WIDTH cycles per product.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   i_start      one-cycle request, latches i_a/i_b (both < P)
//   i_a, i_b     operands
//   o_done       one-cycle pulse, o_p valid in that cycle
//   o_p          product, held until the next i_start
// ---------------------------------------------------------------------------
module ec_modmul
    import ec_pkg::*;
#(
    parameter int WIDTH = EC_DEF_WIDTH,
    parameter int P     = EC_DEF_P
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_p
);

    localparam logic [WIDTH:0] P_EXT = (WIDTH+1)'(P);
    localparam int             CW    = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH:0]   w_dbl;
    logic [WIDTH-1:0] w_dbl_red;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_sum_red;

    // Both partial results stay below 2P, so one conditional subtract suffices.
    always_comb begin
        w_dbl     = {r_acc, 1'b0};
        w_dbl_red = (w_dbl >= P_EXT) ? WIDTH'(w_dbl - P_EXT) : WIDTH'(w_dbl);
        w_sum     = {1'b0, w_dbl_red} + (r_b[WIDTH-1] ? {1'b0, r_a} : '0);
        w_sum_red = (w_sum >= P_EXT) ? WIDTH'(w_sum - P_EXT) : WIDTH'(w_sum);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_a    <= i_a;
                r_b    <= i_b;
                r_acc  <= '0;
                r_cnt  <= CW'(WIDTH);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_acc <= w_sum_red;
                r_b   <= {r_b[WIDTH-2:0], 1'b0};
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done = r_done;
    assign o_p    = r_acc;

endmodule

// File: rtl/ec_point_engine.sv
// ---------------------------------------------------------------------------
// ec_point_engine
// Affine point addition/doubling R = P1 + P2 on y^2 = x^3 + A*x + b over GF(P).
// Special cases (infinity operands, P1 = -P2, doubling with y1 = 0) finish in
// two cycles; everything else runs a fixed multiply schedule on one shared
// ec_modmul so latency depends only on WIDTH and P.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start                 request, sampled while busy = 0 (also in the done cycle)
//   x1, y1, x2, y2        operand coordinates (< P)
//   inf1, inf2            operand is the point at infinity
//   busy                  operation in progress
//   done                  one-cycle pulse, result outputs updated in that cycle
//   x_out, y_out, inf_out result, held until the next done
// ---------------------------------------------------------------------------
module ec_point_engine
    import ec_pkg::*;
#(
    parameter int WIDTH = EC_DEF_WIDTH,
    parameter int P     = EC_DEF_P,
    parameter int A     = EC_DEF_A
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] y1,
    input  logic [WIDTH-1:0] x2,
    input  logic [WIDTH-1:0] y2,
    input  logic             inf1,
    input  logic             inf2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic             inf_out
);

    localparam logic [WIDTH:0]   P_EXT = (WIDTH+1)'(P);
    localparam logic [WIDTH-1:0] P_W   = WIDTH'(P);
    localparam logic [WIDTH-1:0] A_W   = WIDTH'(A);
    localparam logic [WIDTH-1:0] EXP   = WIDTH'(P - 2);
    localparam int               BW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= P_EXT) ? WIDTH'(s - P_EXT) : WIDTH'(s);
    endfunction

    // Borrow out of the widened difference selects the +P correction.
    function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[WIDTH] ? WIDTH'(d[WIDTH-1:0] + P_W) : d[WIDTH-1:0];
    endfunction

    ec_state_t        r_state;
    ec_state_t        w_state_next;

    logic [WIDTH-1:0] r_x1, r_y1, r_x2, r_y2;
    logic             r_inf1, r_inf2;
    logic             r_dbl;
    logic [WIDTH-1:0] r_num, r_den, r_inv, r_s, r_x3;
    logic [BW-1:0]    r_bit;
    logic             r_mulph;     // 0: squaring step, 1: multiply-by-d step
    logic             r_wait;      // a product is in flight in the multiplier
    logic [WIDTH-1:0] r_x_out, r_y_out;
    logic             r_inf_out;

    logic             w_busy;
    logic             w_accept;
    logic             w_mul_state;
    logic             w_mul_issue;
    logic             w_mul_fire;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_p;
    logic [WIDTH-1:0] w_mul_a, w_mul_b;
    logic [WIDTH-1:0] w_x1_sub_x3;
    logic [WIDTH-1:0] w_num_dbl;
    logic             w_exp_bit;
    logic             w_bit_finished;
    logic             w_short;
    logic [WIDTH-1:0] w_short_x, w_short_y;
    logic             w_short_inf;

    assign w_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_accept    = start && !w_busy;
    assign w_mul_state = (r_state == S_NUMDEN) || (r_state == S_INV) ||
                         (r_state == S_SLOPE)  || (r_state == S_XOUT) ||
                         (r_state == S_YOUT);
    assign w_mul_issue = w_mul_state && !r_wait;
    assign w_mul_fire  = r_wait && w_mul_done;

    assign w_x1_sub_x3    = mod_sub(r_x1, r_x3);
    assign w_num_dbl      = mod_add(mod_add(mod_add(w_mul_p, w_mul_p), w_mul_p), A_W);
    assign w_exp_bit      = EXP[r_bit];
    // A bit of the exponent is complete after its square, unless the bit is
    // set, in which case the following multiply-by-d closes it.
    assign w_bit_finished = r_mulph || !w_exp_bit;

    ec_modmul #(
        .WIDTH (WIDTH),
        .P     (P)
    ) u_modmul (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_mul_issue),
        .i_a     (w_mul_a),
        .i_b     (w_mul_b),
        .o_done  (w_mul_done),
        .o_p     (w_mul_p)
    );

    // Operand routing for the single shared multiplier.
    always_comb begin
        w_mul_a = '0;
        w_mul_b = '0;
        case (r_state)
            S_NUMDEN: begin w_mul_a = r_x1;  w_mul_b = r_x1;                      end
            S_INV:    begin w_mul_a = r_inv; w_mul_b = r_mulph ? r_den : r_inv;   end
            S_SLOPE:  begin w_mul_a = r_num; w_mul_b = r_inv;                     end
            S_XOUT:   begin w_mul_a = r_s;   w_mul_b = r_s;                       end
            S_YOUT:   begin w_mul_a = r_s;   w_mul_b = w_x1_sub_x3;               end
            default:  begin w_mul_a = '0;    w_mul_b = '0;                        end
        endcase
    end

    // Cases that need no field arithmetic.
    always_comb begin
        w_short     = 1'b1;
        w_short_x   = '0;
        w_short_y   = '0;
        w_short_inf = 1'b1;
        if (r_inf1 && r_inf2) begin
            w_short_inf = 1'b1;
        end else if (r_inf1) begin
            w_short_x   = r_x2;
            w_short_y   = r_y2;
            w_short_inf = 1'b0;
        end else if (r_inf2) begin
            w_short_x   = r_x1;
            w_short_y   = r_y1;
            w_short_inf = 1'b0;
        end else if ((r_x1 == r_x2) && ((r_y1 != r_y2) || (r_y1 == '0))) begin
            w_short_inf = 1'b1;
        end else begin
            w_short = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_next = S_LOAD;
            S_LOAD:   w_state_next = w_short ? S_DONE : S_NUMDEN;
            S_NUMDEN: if (w_mul_fire) w_state_next = S_INV;
            S_INV:    if (w_mul_fire && w_bit_finished && (r_bit == '0)) w_state_next = S_SLOPE;
            S_SLOPE:  if (w_mul_fire) w_state_next = S_XOUT;
            S_XOUT:   if (w_mul_fire) w_state_next = S_YOUT;
            S_YOUT:   if (w_mul_fire) w_state_next = S_DONE;
            // DONE always lasts one cycle; a start seen here chains directly
            // into the next operation.
            S_DONE:   w_state_next = start ? S_LOAD : S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x1      <= '0;
            r_y1      <= '0;
            r_x2      <= '0;
            r_y2      <= '0;
            r_inf1    <= 1'b0;
            r_inf2    <= 1'b0;
            r_dbl     <= 1'b0;
            r_num     <= '0;
            r_den     <= '0;
            r_inv     <= '0;
            r_s       <= '0;
            r_x3      <= '0;
            r_bit     <= '0;
            r_mulph   <= 1'b0;
            r_wait    <= 1'b0;
            r_x_out   <= '0;
            r_y_out   <= '0;
            r_inf_out <= 1'b1;
        end else begin
            if (w_accept) begin
                r_x1   <= x1;
                r_y1   <= y1;
                r_x2   <= x2;
                r_y2   <= y2;
                r_inf1 <= inf1;
                r_inf2 <= inf2;
            end

            if (w_mul_issue) begin
                r_wait <= 1'b1;
            end else if (w_mul_fire) begin
                r_wait <= 1'b0;
            end

            case (r_state)
                S_LOAD: begin
                    r_dbl <= (r_x1 == r_x2);
                    if (w_short) begin
                        r_x_out   <= w_short_x;
                        r_y_out   <= w_short_y;
                        r_inf_out <= w_short_inf;
                    end
                end
                // x1^2 is always computed so add and double share one schedule.
                S_NUMDEN: if (w_mul_fire) begin
                    r_num   <= r_dbl ? w_num_dbl : mod_sub(r_y2, r_y1);
                    r_den   <= r_dbl ? mod_add(r_y1, r_y1) : mod_sub(r_x2, r_x1);
                    r_inv   <= WIDTH'(1);
                    r_bit   <= BW'(WIDTH - 1);
                    r_mulph <= 1'b0;
                end
                S_INV: if (w_mul_fire) begin
                    r_inv <= w_mul_p;
                    if (w_bit_finished) begin
                        r_mulph <= 1'b0;
                        r_bit   <= r_bit - BW'(1);
                    end else begin
                        r_mulph <= 1'b1;
                    end
                end
                S_SLOPE: if (w_mul_fire) begin
                    r_s <= w_mul_p;
                end
                S_XOUT: if (w_mul_fire) begin
                    r_x3 <= mod_sub(mod_sub(w_mul_p, r_x1), r_x2);
                end
                S_YOUT: if (w_mul_fire) begin
                    r_x_out   <= r_x3;
                    r_y_out   <= mod_sub(w_mul_p, r_y1);
                    r_inf_out <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy    = w_busy;
    assign done    = (r_state == S_DONE);
    assign x_out   = r_x_out;
    assign y_out   = r_y_out;
    assign inf_out = r_inf_out;

endmodule
